// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO and a pollable status word.
module uart_tx_mmio #(
   parameter logic [31:0] BASE_WORD    = 32'h4000_0000,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_data_w,
   input  logic [3:0]  bus_mask_w,
   output logic [31:0] bus_data_r,
   output logic        sel,
   output logic        tx
);

   localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
   localparam int unsigned BaudMaxI = CLKS_PER_BIT - 1;
   localparam logic [15:0] BaudMax  = BaudMaxI[15:0];
   localparam logic [PtrW:0] DepthCnt = FIFO_DEPTH[PtrW:0];

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   // Bus decode
   logic [1:0] off;
   logic       wr_en, push_req, clr_ovf, push_ok, pop;

   // FIFO state
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0] count_q;
   logic          ovf_q;
   logic          full, empty, busy;
   logic [7:0]    count8;
   logic [31:0]   status;

   // Serializer state
   state_e      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;

   // Only the low mask bit qualifies a write; upper data bits beyond the byte are don't-care.
   logic unused_bits;
   assign unused_bits = ^{bus_data_w[31:8], bus_mask_w[3:1]};

   assign sel      = bus_addr[31:2] == BASE_WORD[31:2];
   assign off      = bus_addr[1:0];
   assign wr_en    = sel && bus_mask_w[0];
   assign push_req = wr_en && (off == 2'd0);
   assign clr_ovf  = wr_en && (off == 2'd1) && bus_data_w[3];
   // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req && ((count_q != DepthCnt) || pop);

   assign full   = count_q == DepthCnt;
   assign empty  = count_q == '0;
   assign busy   = state_q != StIdle;
   assign status = {16'b0, count8, 4'b0, ovf_q, busy, empty, full};
   assign tx     = tx_q;

   // Zero-extend the occupancy to the 8-bit status field
   always_comb begin
      count8            = '0;
      count8[PtrW:0]    = count_q;
   end

   // Combinational read mux; TXDATA and STATUS offsets both return the status word
   always_comb begin
      bus_data_r = '0;
      if (sel) begin
         case (off)
            2'd0, 2'd1: bus_data_r = status;
            default:    bus_data_r = '0;
         endcase
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_req && !push_ok) ovf_q <= 1'b1;
         else if (clr_ovf)         ovf_q <= 1'b0;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= bus_data_w[7:0];
   end

   // Serializer next state; tx_d is the line level of the state being entered
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               baud_d  = BaudMax;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_q == '0) begin
               bit_d   = '0;
               baud_d  = BaudMax;
               state_d = StData;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         StData: begin
            if (baud_q == '0) begin
               shift_d = {1'b0, shift_q[7:1]};
               baud_d  = BaudMax;
               if (bit_q == 3'd7) state_d = StStop;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         StStop: begin
            if (baud_q == '0) begin
               if (!empty) begin
                  // Back-to-back frame with no idle gap
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  baud_d  = BaudMax;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // Serializer state register; reset aborts any frame in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed and randomized checks of uart_tx_mmio against a frame-level model.
module tb_uart_tx_mmio;

   localparam logic [31:0] Base = 32'h4000_0000;
   localparam int C = 4;
   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] bus_addr = '0;
   logic [31:0] bus_data_w = '0;
   logic [3:0]  bus_mask_w = '0;
   logic [31:0] bus_data_r;
   logic        sel;
   logic        tx;

   int n_cmp = 0;
   int n_fail = 0;
   logic tx_hist[$];
   logic [31:0] rdata;

   always #5 clock = ~clock;

   uart_tx_mmio #(
      .BASE_WORD   (Base),
      .CLKS_PER_BIT(C),
      .FIFO_DEPTH  (D)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus_addr  (bus_addr),
      .bus_data_w(bus_data_w),
      .bus_mask_w(bus_mask_w),
      .bus_data_r(bus_data_r),
      .sel       (sel),
      .tx        (tx)
   );

   // Line monitor: tx_hist[k] is the tx level after posedge number k
   initial forever begin
      @(posedge clock);
      #2;
      tx_hist.push_back(tx);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected status word from occupancy and flags
   function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit bsy);
      logic [7:0] c8;
      c8 = cnt[7:0];
      return {16'b0, c8, 4'b0, ovf, bsy, (cnt == 0), (cnt == D)};
   endfunction

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      bus_addr   = a;
      bus_data_w = d;
      bus_mask_w = m;
      @(posedge clock);
      #1;
      bus_mask_w = '0;
      bus_data_w = '0;
      bus_addr   = Base + 1;
   endtask

   task automatic rd(input logic [31:0] a);
      bus_addr = a;
      #1;
      rdata = bus_data_r;
   endtask

   task automatic wait_hist(input int need);
      int budget = 5000;
      while (tx_hist.size() <= need && budget > 0) begin
         @(posedge clock);
         #3;
         budget--;
      end
      if (tx_hist.size() <= need) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_hist: observed %0d samples, required more than %0d", tx_hist.size(),
                  need);
      end
   endtask

   // Bytes pushed at edge s while idle: frames start after edge s+1, back to back, then idle.
   task automatic check_stream(input string tag, input int s, input logic [7:0] q[$]);
      int   idx;
      logic exp_b;
      int   tail;
      tail = s + 1 + 10 * C * q.size();
      wait_hist(tail + C);
      for (int f = 0; f < q.size(); f++) begin
         for (int j = 0; j < 10; j++) begin
            if (j == 0)      exp_b = 1'b0;
            else if (j == 9) exp_b = 1'b1;
            else             exp_b = q[f][j-1];
            for (int c = 0; c < C; c++) begin
               idx = s + 1 + (f * 10 + j) * C + c;
               if (idx < tx_hist.size()) check(tag, {31'b0, tx_hist[idx]}, {31'b0, exp_b});
            end
         end
      end
      for (int c = 0; c <= C; c++) begin
         if (tail + c < tx_hist.size()) check({tag, "_idle"}, {31'b0, tx_hist[tail + c]}, 32'd1);
      end
   endtask

   initial begin
      logic [7:0]  q[$];
      logic [7:0]  b;
      logic [31:0] r;
      logic [3:0]  m;
      int e, rr, n, zeros;

      // 1: reset state
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      rd(Base + 1);
      check("reset_status", rdata, 32'h0000_0002);
      check("reset_tx", {31'b0, tx}, 32'd1);
      check("reset_sel", {31'b0, sel}, 32'd1);

      // 2: single frame 0xA5 with per-cycle busy
      q = {};
      q.push_back(8'hA5);
      bus_wr(Base, 32'h0000_00A5, 4'h1);
      e = tx_hist.size();
      rd(Base + 1);
      check("push_latency_tx", {31'b0, tx}, 32'd1);
      check("push_status", rdata, status_word(1, 0, 0));
      for (int j = 1; j <= 10 * C; j++) begin
         @(posedge clock);
         #1;
         check("frame_busy", {31'b0, bus_data_r[2]}, 32'd1);
      end
      @(posedge clock);
      #1;
      check("frame_done_status", bus_data_r, status_word(0, 0, 0));
      check_stream("frame_a5", e, q);

      // 3: three gapless frames and count at frame boundaries
      q = {};
      for (int i = 1; i <= 3; i++) q.push_back(i[7:0]);
      bus_wr(Base, 32'h01, 4'h1);
      e = tx_hist.size();
      bus_wr(Base, 32'h02, 4'h1);
      bus_wr(Base, 32'h03, 4'h1);
      repeat (10 * C - 2) @(posedge clock);
      #1;
      rd(Base + 1);
      check("b2b_count2", rdata, status_word(2, 0, 1));
      @(posedge clock);
      #1;
      rd(Base + 1);
      check("b2b_count1", rdata, status_word(1, 0, 1));
      repeat (10 * C) @(posedge clock);
      #1;
      rd(Base + 1);
      check("b2b_count0", rdata, status_word(0, 0, 1));
      check_stream("b2b", e, q);
      rd(Base + 1);
      check("b2b_idle", rdata, status_word(0, 0, 0));

      // 4: overflow while busy, W1C clear
      q = {};
      b = 8'($urandom);
      q.push_back(b);
      bus_wr(Base, {24'h0, b}, 4'h1);
      e = tx_hist.size();
      repeat (2) @(posedge clock);
      #1;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         if (i < 4) q.push_back(b);
         bus_wr(Base, {24'h0, b}, 4'h1);
      end
      rd(Base + 1);
      check("ovf_status", rdata, status_word(4, 1, 1));
      bus_wr(Base + 1, 32'hFFFF_FFF7, 4'hF);
      rd(Base + 1);
      check("ovf_no_clear", rdata, status_word(4, 1, 1));
      bus_wr(Base + 1, 32'h0000_0008, 4'h1);
      rd(Base + 1);
      check("ovf_cleared", rdata, status_word(4, 0, 1));
      check_stream("ovf_stream", e, q);
      rd(Base + 1);
      check("ovf_idle", rdata, status_word(0, 0, 0));

      // 5: reset during DATA bit 3 discards frame and queue
      b = 8'($urandom);
      bus_wr(Base, {24'h0, b}, 4'h1);
      bus_wr(Base, 32'h0000_0055, 4'h1);
      repeat (4 * C) @(posedge clock);
      #1;
      check("pre_reset_bit3", {31'b0, tx}, {31'b0, b[3]});
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      rr = tx_hist.size();
      check("abort_tx", {31'b0, tx}, 32'd1);
      rd(Base + 1);
      check("abort_status", rdata, 32'h0000_0002);
      wait_hist(rr + 12 * C);
      zeros = 0;
      for (int k = rr; k <= rr + 12 * C && k < tx_hist.size(); k++) if (tx_hist[k] !== 1'b1) zeros++;
      check("abort_no_frame", zeros, 32'd0);

      // 6: decode boundaries
      bus_addr   = Base + 4;
      bus_data_w = 32'h0000_0055;
      bus_mask_w = 4'hF;
      #1;
      check("unsel_sel", {31'b0, sel}, 32'd0);
      check("unsel_data", bus_data_r, 32'd0);
      @(posedge clock);
      #1;
      bus_mask_w = '0;
      rd(Base + 2);
      check("off2_sel", {31'b0, sel}, 32'd1);
      check("off2_data", rdata, 32'd0);
      bus_wr(Base, 32'h0000_0066, 4'hE);
      bus_wr(Base + 3, 32'hFFFF_FFFF, 4'hF);
      e = tx_hist.size();
      rd(Base);
      check("txdata_reads_status", rdata, status_word(0, 0, 0));
      wait_hist(e + 3 * C);
      zeros = 0;
      for (int k = e - 3; k <= e + 3 * C && k < tx_hist.size(); k++) if (tx_hist[k] !== 1'b1) zeros++;
      check("ignored_writes_idle", zeros, 32'd0);

      // Randomized bursts
      for (int it = 0; it < 4; it++) begin
         q = {};
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            r = $urandom;
            m = 4'($urandom) | 4'h1;
            q.push_back(b);
            bus_wr(Base, {r[31:8], b}, m);
            if (i == 0) e = tx_hist.size();
         end
         check_stream("rand_stream", e, q);
         rd(Base + 1);
         check("rand_idle", rdata, status_word(0, 0, 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
